// File: rtl/tlc_pkg.sv
// Shared constants for the four-way traffic light controller and its sensor conditioning front end.
package tlc_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam int unsigned LANE_A = 0;
    localparam int unsigned LANE_B = 1;
    localparam int unsigned LANE_C = 2;
    localparam int unsigned LANE_D = 3;

    // Sensor conditioning defaults
    localparam int unsigned DEB_DEFAULT   = 16;
    localparam int unsigned STUCK_DEFAULT = 1000;

    // Controller phase timing defaults, in clock cycles
    localparam int unsigned T_MIN_GREEN = 10;
    localparam int unsigned T_MAX_GREEN = 60;
    localparam int unsigned T_YELLOW    = 4;
    localparam int unsigned T_ALL_RED   = 2;

    typedef logic [NUM_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/tlc_lane_cond.sv
// One lane of detector conditioning: 2-flop synchroniser, debouncer,
// pending-request latch and stuck-occupied detector.
module tlc_lane_cond
    import tlc_pkg::*;
#(
    parameter int unsigned DEB   = DEB_DEFAULT,
    parameter int unsigned STUCK = STUCK_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic det,
    input  logic green,
    input  logic fault_clr,
    output logic req,
    output logic fault,
    output logic db_level
);

    localparam int unsigned DW = $clog2(DEB);
    localparam int unsigned SW = $clog2(STUCK + 1);

    logic          sync1;
    logic          sync2;
    logic          green_prev;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] stuck_cnt;

    logic db_toggle_c;
    logic db_rise_c;
    logic stuck_hit_c;
    logic stuck_sat_c;

    assign db_toggle_c = (sync2 != db_level) && (db_cnt == DW'(DEB - 1));
    assign db_rise_c   = db_toggle_c && !db_level;
    assign stuck_sat_c = (stuck_cnt == SW'(STUCK));
    assign stuck_hit_c = db_level && (stuck_cnt == SW'(STUCK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            green_prev <= 1'b0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            stuck_cnt  <= '0;
            fault      <= 1'b0;
            req        <= 1'b0;
        end else begin
            sync1      <= det;
            sync2      <= sync1;
            green_prev <= green;

            // Debounce: level changes only after DEB consecutive disagreeing samples
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_toggle_c) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            // Stuck detector; an explicit clear beats the saturating increment
            if (fault_clr) begin
                stuck_cnt <= '0;
                fault     <= 1'b0;
            end else if (!db_level) begin
                stuck_cnt <= '0;
            end else if (!stuck_sat_c) begin
                stuck_cnt <= stuck_cnt + SW'(1);
                if (stuck_hit_c) begin
                    fault <= 1'b1;
                end
            end

            // Green services the request; a faulted lane is always requested when red
            if (green) begin
                req <= 1'b0;
            end else if (fault || db_rise_c || (db_level && green_prev)) begin
                req <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_sensor_cond.sv
// Four-lane vehicle-loop conditioning stage feeding the traffic light controller sensor inputs.
module tlc_sensor_cond
    import tlc_pkg::*;
#(
    parameter int unsigned DEB   = DEB_DEFAULT,
    parameter int unsigned STUCK = STUCK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] det_raw,
    input  logic                 Ga,
    input  logic                 Gb,
    input  logic                 Gc,
    input  logic                 Gd,
    input  logic                 fault_clr,
    output logic                 Sa,
    output logic                 Sb,
    output logic                 Sc,
    output logic                 Sd,
    output logic [NUM_LANES-1:0] fault,
    output logic [NUM_LANES-1:0] db_level
);

    lane_vec_t green;
    lane_vec_t req;

    assign green[LANE_A] = Ga;
    assign green[LANE_B] = Gb;
    assign green[LANE_C] = Gc;
    assign green[LANE_D] = Gd;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tlc_lane_cond #(
            .DEB   (DEB),
            .STUCK (STUCK)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .det       (det_raw[i]),
            .green     (green[i]),
            .fault_clr (fault_clr),
            .req       (req[i]),
            .fault     (fault[i]),
            .db_level  (db_level[i])
        );
    end

    assign Sa = req[LANE_A];
    assign Sb = req[LANE_B];
    assign Sc = req[LANE_C];
    assign Sd = req[LANE_D];

endmodule

// File: tb/tb_tlc_sensor_cond.sv
// Self-checking bench for tlc_sensor_cond with DEB=4, STUCK=64.
module tb_tlc_sensor_cond;

    localparam int unsigned DEB   = 4;
    localparam int unsigned STUCK = 64;

    logic       clk;
    logic       rst_n;
    logic [3:0] det_raw;
    logic       Ga, Gb, Gc, Gd;
    logic       fault_clr;
    logic       Sa, Sb, Sc, Sd;
    logic [3:0] fault;
    logic [3:0] db_level;

    tlc_sensor_cond #(
        .DEB   (DEB),
        .STUCK (STUCK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_raw   (det_raw),
        .Ga        (Ga),
        .Gb        (Gb),
        .Gc        (Gc),
        .Gd        (Gd),
        .fault_clr (fault_clr),
        .Sa        (Sa),
        .Sb        (Sb),
        .Sc        (Sc),
        .Sd        (Sd),
        .fault     (fault),
        .db_level  (db_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;   // {S[d:a], fault, db_level}
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0] det;
        logic [3:0] g;
        int         n;
        logic [3:0] s;
        logic [3:0] db;
        string      tag;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add_row(input logic [3:0] det, input logic [3:0] g, input int n,
                           input logic [3:0] s, input logic [3:0] db, input string tag);
        vec_t v;
        v.det = det; v.g = g; v.n = n; v.s = s; v.db = db; v.tag = tag;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input logic [3:0] es, input logic [3:0] ef,
                            input logic [3:0] edb, input string name);
        exp_t e;
        e.val  = {es, ef, edb};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [11:0] obs;
        e   = sb.pop_front();
        obs = {Sd, Sc, Sb, Sa, fault, db_level};
        n_checks++;
        if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got S=%b fault=%b db=%b, expected S=%b fault=%b db=%b",
                     e.name, obs[11:8], obs[7:4], obs[3:0], e.val[11:8], e.val[7:4], e.val[3:0]);
        end
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs, then sample.
    task automatic step(input logic [3:0] det, input logic [3:0] g, input logic fclr,
                        input logic [3:0] es, input logic [3:0] ef, input logic [3:0] edb,
                        input string name);
        det_raw = det;
        {Gd, Gc, Gb, Ga} = g;
        fault_clr = fclr;
        push_exp(es, ef, edb, name);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        det_raw = 4'b0000;
        {Gd, Gc, Gb, Ga} = 4'b0000;
        fault_clr = 1'b0;

        // Lane b step then serve
        add_row(4'b0010, 4'b0000, 5, 4'b0000, 4'b0000, "b_step_wait");
        add_row(4'b0010, 4'b0000, 3, 4'b0010, 4'b0010, "b_step_rise");
        add_row(4'b0000, 4'b0000, 5, 4'b0010, 4'b0010, "b_drop_db_hold");
        add_row(4'b0000, 4'b0000, 2, 4'b0010, 4'b0000, "b_req_kept");
        add_row(4'b0000, 4'b0010, 3, 4'b0000, 4'b0000, "b_green_clear");
        add_row(4'b0000, 4'b0000, 4, 4'b0000, 4'b0000, "b_after_green");
        // Lane a bounce: 1,2,3-cycle pulses then a clean hold
        add_row(4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, "a_bounce1");
        add_row(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "a_gap1");
        add_row(4'b0001, 4'b0000, 2, 4'b0000, 4'b0000, "a_bounce2");
        add_row(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "a_gap2");
        add_row(4'b0001, 4'b0000, 3, 4'b0000, 4'b0000, "a_bounce3");
        add_row(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, "a_gap3");
        add_row(4'b0001, 4'b0000, 5, 4'b0000, 4'b0000, "a_hold_wait");
        add_row(4'b0001, 4'b0000, 3, 4'b0001, 4'b0001, "a_hold_rise");
        add_row(4'b0000, 4'b0000, 5, 4'b0001, 4'b0001, "a_drop");
        add_row(4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, "a_db_fall");
        add_row(4'b0000, 4'b0001, 1, 4'b0000, 4'b0000, "a_serve");
        // Lane c detected during its green, re-requests when green ends
        add_row(4'b0100, 4'b0100, 5, 4'b0000, 4'b0000, "c_green_wait");
        add_row(4'b0100, 4'b0100, 5, 4'b0000, 4'b0100, "c_green_no_set");
        add_row(4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, "c_green_end_set");
        add_row(4'b0100, 4'b0000, 2, 4'b0100, 4'b0100, "c_hold");
        add_row(4'b0000, 4'b0000, 5, 4'b0100, 4'b0100, "c_drop");
        add_row(4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, "c_db_fall");
        add_row(4'b0000, 4'b0100, 1, 4'b0000, 4'b0000, "c_serve");
        add_row(4'b0000, 4'b0000, 2, 4'b0000, 4'b0000, "c_idle");

        // Reset state: async, before any edge
        #1;
        push_exp(4'b0000, 4'b0000, 4'b0000, "reset_async_initial");
        check_out();
        repeat (2) begin
            @(posedge clk);
            #1;
            push_exp(4'b0000, 4'b0000, 4'b0000, "reset_held");
            check_out();
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("idle_cyc%0d", i));

        for (int r = 0; r < tbl.size(); r++)
            for (int k = 0; k < tbl[r].n; k++)
                step(tbl[r].det, tbl[r].g, 1'b0, tbl[r].s, 4'b0000, tbl[r].db,
                     $sformatf("%s_row%0d_cyc%0d", tbl[r].tag, r, k));

        // Lane d stuck: fault at 64 cycles after db rise, clear, clear-on-saturation, re-fault
        for (int i = 1; i <= 212; i++) begin
            logic [3:0] es, ef;
            es = (i >= 6) ? 4'b1000 : 4'b0000;
            ef = (((i >= 70) && (i < 81)) || (i >= 209)) ? 4'b1000 : 4'b0000;
            step(4'b1000, 4'b0000, ((i == 81) || (i == 145)), es, ef, es,
                 $sformatf("d_stuck_cyc%0d", i));
        end
        for (int j = 1; j <= 8; j++)
            step(4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000,
                 (j < 6) ? 4'b1000 : 4'b0000, $sformatf("d_green_fault_cyc%0d", j));
        for (int j = 1; j <= 3; j++)
            step(4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0000,
                 $sformatf("d_failsafe_cyc%0d", j));
        step(4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 4'b0000, "d_fault_clr");
        step(4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "d_serve");
        for (int j = 1; j <= 2; j++)
            step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("d_idle_cyc%0d", j));

        // Async reset mid-request (Sa=1) and mid-debounce (lane b counter=2)
        for (int i = 1; i <= 6; i++)
            step(4'b0001, 4'b0000, 1'b0, (i >= 6) ? 4'b0001 : 4'b0000, 4'b0000,
                 (i >= 6) ? 4'b0001 : 4'b0000, $sformatf("rst_a_set_cyc%0d", i));
        for (int i = 1; i <= 4; i++)
            step(4'b0011, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001,
                 $sformatf("rst_b_partial_cyc%0d", i));
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(4'b0000, 4'b0000, 4'b0000, "rst_async_mid");
        check_out();
        for (int i = 0; i < 3; i++)
            step(4'b0011, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("rst_held_cyc%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++)
            step(4'b0011, 4'b0000, 1'b0, (i >= 6) ? 4'b0011 : 4'b0000, 4'b0000,
                 (i >= 6) ? 4'b0011 : 4'b0000, $sformatf("post_rst_cyc%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
